// File: rtl/dual_async_bidir_buffer_y_drain.sv
// Y-side drain engine: round-robins between the A->Y and B->Y FIFOs of the
// dual async bidirectional buffer and emits channel-tagged byte bursts.
// Everything runs in the Y clock domain.
module dual_async_bidir_buffer_y_drain #(
  parameter int MAX_BURST = 64
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] ch_en_i,
  output logic       Y_sel_o,
  output logic       Y_rd_o,
  input  logic       Y_empty_i,
  input  logic [7:0] Y_dat_i,
  output logic [7:0] out_dat_o,
  output logic       out_chan_o,
  output logic       out_last_o,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic       busy_o
);

  localparam logic [7:0] MAX_B = 8'(MAX_BURST);

  typedef enum logic [2:0] {
    S_SETTLE, S_IDLE, S_READ, S_CAPTURE, S_CHECK, S_SEND
  } state_t;

  state_t      state_q, state_d;
  logic        sel_q, sel_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic        chan_q, chan_d;
  logic [7:0]  dat_q, dat_d;
  logic [7:0]  beat_q, beat_d;
  logic [7:0]  hold_q, hold_d;

  // Next-state and output-register logic for the drain sequence.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    last_d  = last_q;
    chan_d  = chan_q;
    dat_d   = dat_q;
    beat_d  = beat_q;
    hold_d  = hold_q;
    case (state_q)
      // Empty/data from the buffer are only trusted one full cycle after a select change.
      S_SETTLE: state_d = S_IDLE;
      S_IDLE: begin
        if (ch_en_i[sel_q] && !Y_empty_i) begin
          state_d = S_READ;
        end else begin
          sel_d   = ~sel_q;
          state_d = S_SETTLE;
        end
      end
      S_READ: state_d = S_CAPTURE;
      S_CAPTURE: begin
        hold_d  = Y_dat_i;
        beat_d  = beat_q + 8'd1;
        state_d = S_CHECK;
      end
      // Empty flag now reflects the pointer after this read, so it decides "last".
      S_CHECK: begin
        dat_d   = hold_q;
        chan_d  = sel_q;
        valid_d = 1'b1;
        last_d  = Y_empty_i || (beat_q == MAX_B);
        state_d = S_SEND;
      end
      S_SEND: begin
        if (out_ready_i) begin
          valid_d = 1'b0;
          if (last_q) begin
            beat_d  = 8'd0;
            sel_d   = ~sel_q;
            state_d = S_SETTLE;
          end else begin
            // This block is the only reader, so the channel is known non-empty.
            state_d = S_READ;
          end
        end
      end
      default: state_d = S_SETTLE;
    endcase
  end

  // Control and stream-output registers; async reset restarts at SETTLE on channel A.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_SETTLE;
      sel_q   <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      chan_q  <= 1'b0;
      dat_q   <= 8'd0;
      beat_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      chan_q  <= chan_d;
      dat_q   <= dat_d;
      beat_q  <= beat_d;
    end
  end

  // Captured byte holding register; a reset simply drops its contents.
  always_ff @(posedge clk_i) begin
    hold_q <= hold_d;
  end

  assign Y_sel_o     = sel_q;
  assign Y_rd_o      = (state_q == S_READ);
  assign out_dat_o   = dat_q;
  assign out_chan_o  = chan_q;
  assign out_last_o  = last_q;
  assign out_valid_o = valid_q;
  assign busy_o      = !((state_q == S_IDLE) || (state_q == S_SETTLE));

endmodule

// File: tb/tb_dual_async_bidir_buffer_y_drain.sv
// Testbench for dual_async_bidir_buffer_y_drain: models the two buffer FIFOs,
// collects stream transfers and compares against a burst-level reference.
module tb_dual_async_bidir_buffer_y_drain;

  localparam int MAXB = 64;

  typedef struct packed {
    logic [7:0] d;
    logic       c;
    logic       l;
  } beat_t;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [1:0] ch_en_i = 2'b11;
  logic       Y_sel_o;
  logic       Y_rd_o;
  logic       Y_empty_i;
  logic [7:0] Y_dat_i = 8'd0;
  logic [7:0] out_dat_o;
  logic       out_chan_o;
  logic       out_last_o;
  logic       out_valid_o;
  logic       out_ready_i = 1'b1;
  logic       busy_o;

  dual_async_bidir_buffer_y_drain #(.MAX_BURST(MAXB)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .ch_en_i(ch_en_i),
    .Y_sel_o(Y_sel_o), .Y_rd_o(Y_rd_o), .Y_empty_i(Y_empty_i), .Y_dat_i(Y_dat_i),
    .out_dat_o(out_dat_o), .out_chan_o(out_chan_o), .out_last_o(out_last_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Buffer FIFO model: writes from the stimulus, reads by the DUT.
  logic [7:0] mem_a [0:1023];
  logic [7:0] mem_b [0:1023];
  logic [9:0] wp_a = 10'd0, wp_b = 10'd0;
  logic [9:0] rp_a = 10'd0, rp_b = 10'd0;

  assign Y_empty_i = Y_sel_o ? (wp_b == rp_b) : (wp_a == rp_a);

  always @(posedge clk_i) begin
    if (rst_i) begin
      rp_a <= 10'd0;
      rp_b <= 10'd0;
    end else if (Y_rd_o) begin
      if (Y_sel_o) begin
        Y_dat_i <= mem_b[rp_b];
        rp_b    <= rp_b + 10'd1;
      end else begin
        Y_dat_i <= mem_a[rp_a];
        rp_a    <= rp_a + 10'd1;
      end
    end
  end

  // Monitor: records transfers and counts protocol violations.
  beat_t      obs_q [$];
  int         rd_a = 0, rd_b = 0;
  int         rd_err = 0, rdv_err = 0, stab_err = 0, sel_err = 0;
  logic       prev_hold = 1'b0;
  logic [9:0] prev_out = 10'd0;
  logic       pend_sel = 1'b0;
  logic       exp_sel = 1'b0;

  always @(negedge clk_i) begin
    if (rst_i) begin
      prev_hold = 1'b0;
      pend_sel  = 1'b0;
    end else begin
      if (Y_rd_o) begin
        if (Y_sel_o) rd_b++; else rd_a++;
        if (Y_empty_i) rd_err++;
        if (out_valid_o) rdv_err++;
      end
      if (prev_hold && (!out_valid_o || {out_dat_o, out_chan_o, out_last_o} !== prev_out))
        stab_err++;
      if (pend_sel && (Y_sel_o !== exp_sel)) sel_err++;
      pend_sel = 1'b0;
      if (out_valid_o && out_ready_i) begin
        obs_q.push_back('{d: out_dat_o, c: out_chan_o, l: out_last_o});
        if (out_last_o) begin
          pend_sel = 1'b1;
          exp_sel  = ~out_chan_o;
        end
      end
      prev_hold = out_valid_o && !out_ready_i;
      prev_out  = {out_dat_o, out_chan_o, out_last_o};
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int base    = 0;
  logic [7:0] src_a [$];
  logic [7:0] src_b [$];
  beat_t      exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_a(input logic [7:0] b);
    mem_a[wp_a] = b;
    wp_a = wp_a + 10'd1;
    src_a.push_back(b);
  endtask

  task automatic push_b(input logic [7:0] b);
    mem_b[wp_b] = b;
    wp_b = wp_b + 10'd1;
    src_b.push_back(b);
  endtask

  // Enter reset with empty FIFOs; data is loaded while reset is held.
  task automatic start_reset();
    rst_i = 1'b1;
    out_ready_i = 1'b1;
    tick();
    tick();
    wp_a = 10'd0;
    wp_b = 10'd0;
    src_a.delete();
    src_b.delete();
    base = obs_q.size();
  endtask

  // Reference: alternate A/B starting at A; each enabled non-empty turn yields
  // up to MAXB bytes, the final one flagged last.
  task automatic build_exp(input logic [1:0] en);
    logic [7:0] qa [$];
    logic [7:0] qb [$];
    int ch;
    int n;
    beat_t b;
    qa = src_a;
    qb = src_b;
    exp_q.delete();
    ch = 0;
    while ((en[0] && qa.size() > 0) || (en[1] && qb.size() > 0)) begin
      if (en[ch]) begin
        n = 0;
        while (n < MAXB && ((ch == 0) ? qa.size() : qb.size()) > 0) begin
          b.d = (ch == 0) ? qa.pop_front() : qb.pop_front();
          b.c = ch[0];
          n++;
          b.l = (n == MAXB) || (((ch == 0) ? qa.size() : qb.size()) == 0);
          exp_q.push_back(b);
        end
      end
      ch ^= 1;
    end
  endtask

  // Wait (bounded) for the expected transfers, then compare them in order.
  task automatic run_phase(input string tag, input bit rnd_ready);
    int n;
    n = exp_q.size();
    for (int c = 0; c < 6000 && obs_q.size() < base + n; c++) begin
      if (rnd_ready) out_ready_i = ($urandom_range(0, 3) != 0);
      tick();
    end
    out_ready_i = 1'b1;
    check({tag, "_count"}, 32'(obs_q.size() - base), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (base + i < obs_q.size())
        check($sformatf("%s_beat%0d", tag, i), 32'(obs_q[base + i]), 32'(exp_q[i]));
    end
    for (int c = 0; c < 30; c++) tick();
    check({tag, "_no_extra"}, 32'(obs_q.size() - base), 32'(n));
  endtask

  initial begin
    int ra;
    int rb;
    int t;
    logic [7:0] d0;

    // Reset state
    start_reset();
    @(negedge clk_i);
    check("reset_outputs",
          {24'd0, Y_sel_o, Y_rd_o, out_valid_o, out_last_o, out_chan_o, busy_o, 2'b00},
          32'd0);
    check("reset_dat", 32'(out_dat_o), 32'd0);

    // 1: three bytes on A, latency and per-byte reads
    ch_en_i = 2'b11;
    push_a(8'h11); push_a(8'h22); push_a(8'h33);
    build_exp(2'b11);
    ra = rd_a;
    tick();
    rst_i = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    @(negedge clk_i);
    check("t1_valid_before_latency", 32'(out_valid_o), 32'd0);
    tick();
    @(negedge clk_i);
    check("t1_valid_at_latency", 32'(out_valid_o), 32'd1);
    run_phase("t1", 1'b0);
    check("t1_rd_pulses", 32'(rd_a - ra), 32'd3);

    // 2: 70 bytes on A, 2 on B, random backpressure
    start_reset();
    for (int i = 0; i < 70; i++) push_a(8'($urandom));
    push_b(8'($urandom)); push_b(8'($urandom));
    build_exp(2'b11);
    tick();
    rst_i = 1'b0;
    run_phase("t2", 1'b1);

    // 3: ready held low for 20 cycles while a byte is presented
    start_reset();
    ch_en_i = 2'b01;
    push_a(8'hC3); push_a(8'h3C);
    build_exp(2'b01);
    out_ready_i = 1'b0;
    tick();
    rst_i = 1'b0;
    t = 0;
    while (!out_valid_o && t < 200) begin
      tick();
      t++;
    end
    check("t3_valid_seen", 32'(out_valid_o), 32'd1);
    ra = rd_a;
    t = stab_err;
    d0 = out_dat_o;
    for (int c = 0; c < 20; c++) tick();
    @(negedge clk_i);
    check("t3_held_valid", 32'(out_valid_o), 32'd1);
    check("t3_held_dat", 32'(out_dat_o), 32'(d0));
    check("t3_first_byte", 32'(d0), 32'h0C3);
    check("t3_no_rd", 32'(rd_a - ra), 32'd0);
    check("t3_stable", 32'(stab_err - t), 32'd0);
    out_ready_i = 1'b1;
    run_phase("t3", 1'b0);

    // 4: only channel B enabled
    start_reset();
    ch_en_i = 2'b10;
    for (int i = 0; i < 5; i++) push_a(8'($urandom));
    for (int i = 0; i < 4; i++) push_b(8'($urandom));
    build_exp(2'b10);
    ra = rd_a;
    tick();
    rst_i = 1'b0;
    run_phase("t4", 1'b1);
    check("t4_a_untouched", 32'(rd_a - ra), 32'd0);
    check("t4_a_ptr", 32'(rp_a), 32'd0);

    // 5: reset during CAPTURE on channel B
    start_reset();
    ch_en_i = 2'b10;
    push_b(8'h77); push_b(8'h78);
    tick();
    rst_i = 1'b0;
    rb = 0;
    t = 0;
    while (t < 200 && rb == 0) begin
      @(negedge clk_i);
      if (Y_rd_o) rb = 1;
      t++;
    end
    check("t5_read_seen", 32'(rb), 32'd1);
    check("t5_sel_b", 32'(Y_sel_o), 32'd1);
    tick();
    rst_i = 1'b1;
    @(negedge clk_i);
    check("t5_after_reset",
          {28'd0, out_valid_o, Y_rd_o, Y_sel_o, busy_o}, 32'd0);

    // 5b: after release the sequence restarts from SETTLE on channel A
    start_reset();
    ch_en_i = 2'b11;
    push_a(8'h5A);
    build_exp(2'b11);
    tick();
    rst_i = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    @(negedge clk_i);
    check("t5_restart_not_yet", 32'(out_valid_o), 32'd0);
    tick();
    @(negedge clk_i);
    check("t5_restart_valid", 32'(out_valid_o), 32'd1);
    run_phase("t5b", 1'b0);

    // 6: byte written to empty A while its last byte is presented
    start_reset();
    ch_en_i = 2'b11;
    push_a(8'h96);
    exp_q.delete();
    exp_q.push_back('{d: 8'h96, c: 1'b0, l: 1'b1});
    exp_q.push_back('{d: 8'hA7, c: 1'b0, l: 1'b1});
    out_ready_i = 1'b0;
    tick();
    rst_i = 1'b0;
    t = 0;
    while (!(out_valid_o && out_last_o) && t < 200) begin
      tick();
      t++;
    end
    check("t6_last_seen", 32'(out_valid_o && out_last_o), 32'd1);
    push_a(8'hA7);
    out_ready_i = 1'b1;
    run_phase("t6", 1'b0);

    // Protocol invariants over the whole run
    check("rd_on_empty", 32'(rd_err), 32'd0);
    check("rd_while_valid", 32'(rdv_err), 32'd0);
    check("out_stability", 32'(stab_err), 32'd0);
    check("sel_toggle_after_last", 32'(sel_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
